load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit bridging byte-addressed requests onto an aligned word bus
module load_store_unit #(
    parameter int MISALIGNED_EN = 1,
    parameter int TIMEOUT_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        split_q, split_d;
    logic [31:0] wdata_hi_q, wdata_hi_d;
    logic [3:0]  be_hi_q, be_hi_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        size_legal;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic [3:0]  base_mask;
    logic [7:0]  lane_mask;
    logic [63:0] lane_data;
    logic        beat_timeout;

    // Shift the two-word window down to the access offset, then size and extend it
    function automatic logic [31:0] load_extend(input logic [63:0] words,
                                                input logic [1:0]  off,
                                                input logic [2:0]  size);
        logic [63:0] sh;
        sh = words >> {off, 3'b000};
        case (size)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd2:    return sh[31:0];
            3'd3:    return {24'd0, sh[7:0]};
            3'd4:    return {16'd0, sh[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    // Decode the incoming request: legality, alignment and store lane placement
    always_comb begin
        size_legal = (req_size <= 3'd4);
        is_half    = (req_size == 3'd1) || (req_size == 3'd4);
        is_word    = (req_size == 3'd2);
        misaligned = (is_half && (req_addr[1:0] == 2'b11)) ||
                     (is_word && (req_addr[1:0] != 2'b00));
        base_mask  = is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001);
        lane_mask  = {4'b0000, base_mask} << req_addr[1:0];
        lane_data  = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
        beat_timeout = ((cnt_q + 8'd1) == TIMEOUT_LIM);
    end

    // Next-state logic: an ack always wins over a timeout reached on the same cycle
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        off_d       = off_q;
        split_d     = split_q;
        wdata_hi_d  = wdata_hi_q;
        be_hi_d     = be_hi_q;
        rdata0_d    = rdata0_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    size_d = req_size;
                    off_d  = req_addr[1:0];
                    if (!size_legal || (misaligned && (MISALIGNED_EN == 0))) begin
                        state_d     = S_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d     = S_BEAT0;
                        split_d     = misaligned;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = req_we ? lane_mask[3:0] : 4'b0000;
                        mem_wdata_d = req_we ? lane_data[31:0] : 32'd0;
                        be_hi_d     = req_we ? lane_mask[7:4] : 4'b0000;
                        wdata_hi_d  = req_we ? lane_data[63:32] : 32'd0;
                    end
                end
            end
            S_BEAT0: begin
                if (mem_ack) begin
                    cnt_d = 8'd0;
                    if (split_q) begin
                        state_d     = S_BEAT1;
                        rdata0_d    = mem_rdata;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_be_d    = be_hi_q;
                        mem_wdata_d = wdata_hi_q;
                    end else begin
                        state_d     = S_RESP;
                        mem_req_d   = 1'b0;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = we_q ? 32'd0
                                           : load_extend({32'd0, mem_rdata}, off_q, size_q);
                    end
                end else if (beat_timeout) begin
                    state_d     = S_RESP;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_BEAT1: begin
                if (mem_ack) begin
                    state_d     = S_RESP;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? 32'd0
                                       : load_extend({mem_rdata, rdata0_q}, off_q, size_q);
                end else if (beat_timeout) begin
                    state_d     = S_RESP;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bus registers; reset abandons any access in flight without a response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 3'd0;
            off_q       <= 2'd0;
            split_q     <= 1'b0;
            wdata_hi_q  <= 32'd0;
            be_hi_q     <= 4'd0;
            rdata0_q    <= 32'd0;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            off_q       <= off_d;
            split_q     <= split_d;
            wdata_hi_q  <= wdata_hi_d;
            be_hi_q     <= be_hi_d;
            rdata0_q    <= rdata0_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel, req_valid, req_we, mem_ack;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err, a_mem_req, a_mem_we, a_mem_ack;
    logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_be;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err, b_mem_req, b_mem_we, b_mem_ack;
    logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;

    assign a_req_valid = req_valid && !sel;
    assign b_req_valid = req_valid && sel;
    assign a_mem_ack   = mem_ack && !sel;
    assign b_mem_ack   = mem_ack && sel;

    logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign mem_req   = sel ? b_mem_req   : a_mem_req;
    assign mem_we    = sel ? b_mem_we    : a_mem_we;
    assign mem_addr  = sel ? b_mem_addr  : a_mem_addr;
    assign mem_be    = sel ? b_mem_be    : a_mem_be;
    assign mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

    load_store_unit #(.MISALIGNED_EN(1), .TIMEOUT_CYC(TO)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
        .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack), .mem_rdata(mem_rdata));

    load_store_unit #(.MISALIGNED_EN(0), .TIMEOUT_CYC(TO)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
        .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(mem_rdata));

    int total = 0;
    int bad   = 0;

    int          obs_beats, obs_rsp, obs_lat, obs_unstable, obs_req_cycles;
    logic        obs_ready, obs_err;
    logic [31:0] obs_rdata;
    logic [31:0] obs_addr [2];
    logic [3:0]  obs_be [2];
    logic [31:0] obs_wdata [2];
    logic        obs_we [2];

    function automatic int nbytes(input logic [2:0] size);
        case (size)
            3'd0, 3'd3: return 1;
            3'd1, 3'd4: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Reference load result: pick bytes out of the little-endian byte image of the two words
    function automatic logic [31:0] model_load(input logic [2:0] size, input logic [1:0] off,
                                               input logic [31:0] r0, input logic [31:0] r1);
        logic [7:0]  bytes [8];
        logic [31:0] v;
        int n;
        for (int i = 0; i < 4; i++) begin
            bytes[i]     = r0[8*i +: 8];
            bytes[4 + i] = r1[8*i +: 8];
        end
        n = nbytes(size);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(bytes[int'(off) + i]) << (8 * i));
        if ((size == 3'd0 || size == 3'd1) && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // Issue one request and play the memory side; d0/d1 are ack delays per beat (>=TO means never)
    task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input int d0, input int d1,
                              input logic [31:0] r0, input logic [31:0] r1);
        int beat, waitc;
        logic prev_ack;
        obs_beats = 0; obs_rsp = 0; obs_lat = -1; obs_unstable = 0; obs_req_cycles = 0;
        obs_err = 1'b0; obs_rdata = 32'd0;
        obs_ready = req_ready;
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        beat = -1; waitc = 0; prev_ack = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (rsp_valid) begin
                obs_rsp++;
                if (obs_lat < 0) begin
                    obs_lat = cyc; obs_rdata = rsp_rdata; obs_err = rsp_err;
                end
            end
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (mem_req) begin
                obs_req_cycles++;
                if (beat < 0 || prev_ack) begin
                    beat++; waitc = 0; obs_beats = beat + 1;
                    if (beat < 2) begin
                        obs_addr[beat] = mem_addr; obs_be[beat] = mem_be;
                        obs_wdata[beat] = mem_wdata; obs_we[beat] = mem_we;
                    end
                end else if (beat < 2 && (mem_addr !== obs_addr[beat] || mem_be !== obs_be[beat] ||
                             mem_wdata !== obs_wdata[beat] || mem_we !== obs_we[beat])) begin
                    obs_unstable++;
                end
                if (waitc == ((beat == 0) ? d0 : d1)) begin
                    mem_ack = 1'b1; mem_rdata = (beat == 0) ? r0 : r1;
                end
                waitc++;
            end
            prev_ack = mem_ack;
            if (obs_lat >= 0 && cyc >= obs_lat + 1) break;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", a_req_ready); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", a_rsp_valid); end
        total++; if ({a_rsp_err, a_rsp_rdata} !== 33'd0) begin bad++; $display("FAIL rst_rsp got=%h want=0", {a_rsp_err, a_rsp_rdata}); end
        total++; if ({a_mem_req, a_mem_we, a_mem_be} !== 6'd0) begin bad++; $display("FAIL rst_mem_ctl got=%b want=0", {a_mem_req, a_mem_we, a_mem_be}); end
        total++; if ({a_mem_addr, a_mem_wdata} !== 64'd0) begin bad++; $display("FAIL rst_mem_data got=%h want=0", {a_mem_addr, a_mem_wdata}); end
        total++; if ({b_req_ready, b_rsp_valid, b_mem_req} !== 3'b100) begin bad++; $display("FAIL rst_b_ctl got=%b want=100", {b_req_ready, b_rsp_valid, b_mem_req}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        sel = 1'b0;
        // load byte signed at 0x1003
        run_access(1'b0, 3'd0, 32'h1003, 32'h0, 2, 0, 32'h80AABBCC, 32'h0);
        total++; if (obs_beats !== 1 || obs_addr[0] !== 32'h1000) begin bad++; $display("FAIL lb_beat got=%0d/%h want=1/00001000", obs_beats, obs_addr[0]); end
        total++; if (obs_be[0] !== 4'b0000) begin bad++; $display("FAIL lb_be got=%b want=0000", obs_be[0]); end
        total++; if (obs_rdata !== 32'hFFFFFF80 || obs_err !== 1'b0) begin bad++; $display("FAIL lb_rsp got=%h/%b want=ffffff80/0", obs_rdata, obs_err); end
        total++; if (obs_lat !== 4 || obs_rsp !== 1) begin bad++; $display("FAIL lb_latency got=%0d/%0d want=4/1", obs_lat, obs_rsp); end
        // misaligned store word split across two beats
        run_access(1'b1, 3'd2, 32'h2002, 32'hDEADBEEF, 1, 0, 32'h0, 32'h0);
        total++; if (obs_beats !== 2) begin bad++; $display("FAIL sw_beats got=%0d want=2", obs_beats); end
        total++; if (obs_addr[0] !== 32'h2000 || obs_be[0] !== 4'b1100 || obs_wdata[0] !== 32'hBEEF0000) begin bad++; $display("FAIL sw_beat0 got=%h/%b/%h want=00002000/1100/beef0000", obs_addr[0], obs_be[0], obs_wdata[0]); end
        total++; if (obs_addr[1] !== 32'h2004 || obs_be[1] !== 4'b0011 || obs_wdata[1] !== 32'h0000DEAD) begin bad++; $display("FAIL sw_beat1 got=%h/%b/%h want=00002004/0011/0000dead", obs_addr[1], obs_be[1], obs_wdata[1]); end
        total++; if (obs_rsp !== 1 || obs_lat !== 4 || obs_err !== 1'b0 || obs_rdata !== 32'd0) begin bad++; $display("FAIL sw_rsp got=%0d/%0d/%b/%h want=1/4/0/0", obs_rsp, obs_lat, obs_err, obs_rdata); end
        // misaligned load halfword unsigned at 0x0003
        run_access(1'b0, 3'd4, 32'h0003, 32'h0, 0, 2, 32'hAB000000, 32'h000000CD);
        total++; if (obs_rdata !== 32'h0000CDAB || obs_err !== 1'b0) begin bad++; $display("FAIL lhu_rsp got=%h/%b want=0000cdab/0", obs_rdata, obs_err); end
        total++; if (obs_addr[1] !== 32'h4 || obs_lat !== 5 || obs_unstable !== 0) begin bad++; $display("FAIL lhu_beat1 got=%h/%0d/%0d want=00000004/5/0", obs_addr[1], obs_lat, obs_unstable); end
    endtask

    task automatic test_reject;
        sel = 1'b1;
        run_access(1'b0, 3'd2, 32'h0001, 32'h0, 0, 0, 32'h11111111, 32'h0);
        total++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'd0) begin bad++; $display("FAIL rej_mis got=%0d/%b/%h want=1/1/0", obs_lat, obs_err, obs_rdata); end
        total++; if (obs_req_cycles !== 0 || obs_rsp !== 1) begin bad++; $display("FAIL rej_mis_bus got=%0d/%0d want=0/1", obs_req_cycles, obs_rsp); end
        run_access(1'b1, 3'd6, 32'h0100, 32'h12345678, 0, 0, 32'h0, 32'h0);
        total++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_req_cycles !== 0) begin bad++; $display("FAIL rej_size6 got=%0d/%b/%0d want=1/1/0", obs_lat, obs_err, obs_req_cycles); end
        run_access(1'b0, 3'd1, 32'h0102, 32'h0, 1, 0, 32'h8001AAAA, 32'h0);
        total++; if (obs_err !== 1'b0 || obs_rdata !== 32'hFFFF8001 || obs_beats !== 1) begin bad++; $display("FAIL b_lh_off2 got=%b/%h/%0d want=0/ffff8001/1", obs_err, obs_rdata, obs_beats); end
        run_access(1'b1, 3'd3, 32'h0103, 32'h000000A5, 0, 0, 32'h0, 32'h0);
        total++; if (obs_err !== 1'b0 || obs_be[0] !== 4'b1000 || obs_wdata[0] !== 32'hA5000000) begin bad++; $display("FAIL b_sb_off3 got=%b/%b/%h want=0/1000/a5000000", obs_err, obs_be[0], obs_wdata[0]); end
        sel = 1'b0;
        run_access(1'b0, 3'd7, 32'h0200, 32'h0, 0, 0, 32'h0, 32'h0);
        total++; if (obs_lat !== 1 || obs_err !== 1'b1 || obs_req_cycles !== 0) begin bad++; $display("FAIL rej_size7 got=%0d/%b/%0d want=1/1/0", obs_lat, obs_err, obs_req_cycles); end
    endtask

    task automatic test_timeout;
        sel = 1'b0;
        run_access(1'b0, 3'd2, 32'h0040, 32'h0, 100, 0, 32'h0, 32'h0);
        total++; if (obs_req_cycles !== TO || obs_lat !== TO + 1) begin bad++; $display("FAIL to_cycles got=%0d/%0d want=%0d/%0d", obs_req_cycles, obs_lat, TO, TO + 1); end
        total++; if (obs_err !== 1'b1 || obs_rdata !== 32'd0 || obs_rsp !== 1) begin bad++; $display("FAIL to_rsp got=%b/%h/%0d want=1/0/1", obs_err, obs_rdata, obs_rsp); end
        run_access(1'b0, 3'd2, 32'h0040, 32'h0, TO - 1, 0, 32'h12345678, 32'h0);
        total++; if (obs_err !== 1'b0 || obs_rdata !== 32'h12345678 || obs_lat !== TO + 1) begin bad++; $display("FAIL to_edge_ack got=%b/%h/%0d want=0/12345678/%0d", obs_err, obs_rdata, obs_lat, TO + 1); end
        run_access(1'b1, 3'd2, 32'h0041, 32'hCAFEF00D, 1, 100, 32'h0, 32'h0);
        total++; if (obs_beats !== 2 || obs_err !== 1'b1 || obs_lat !== TO + 3) begin bad++; $display("FAIL to_beat1 got=%0d/%b/%0d want=2/1/%0d", obs_beats, obs_err, obs_lat, TO + 3); end
    endtask

    task automatic test_random;
        logic we; logic [2:0] size; logic [31:0] addr, wdata, r0, r1;
        int d0, d1, n, e_beats, e_lat; logic e_err; logic [31:0] e_rdata;
        logic [1:0] off; logic mis; logic [63:0] lane; logic [7:0] mask8;
        sel = 1'b0;
        for (int it = 0; it < 60; it++) begin
            we = 1'($urandom);
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            addr = $urandom; wdata = $urandom; r0 = $urandom; r1 = $urandom;
            d0 = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, TO - 1);
            d1 = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, TO - 1);
            n = nbytes(size); off = addr[1:0];
            mis = (n > 0) && (int'(off) + n > 4);
            lane = 64'(wdata) << (8 * int'(off));
            mask8 = 8'd0;
            for (int i = 0; i < n; i++) mask8[int'(off) + i] = 1'b1;
            e_rdata = 32'd0; e_err = 1'b1;
            if (n == 0) begin e_beats = 0; e_lat = 1; end
            else if (d0 >= TO) begin e_beats = 1; e_lat = TO + 1; end
            else if (!mis) begin e_beats = 1; e_lat = d0 + 2; e_err = 1'b0; end
            else if (d1 >= TO) begin e_beats = 2; e_lat = d0 + TO + 2; end
            else begin e_beats = 2; e_lat = d0 + d1 + 3; e_err = 1'b0; end
            if (!e_err && !we) e_rdata = model_load(size, off, r0, r1);
            run_access(we, size, addr, wdata, d0, d1, r0, r1);
            total++; if (obs_ready !== 1'b1 || obs_rsp !== 1 || obs_lat !== e_lat) begin bad++; $display("FAIL rnd%0d_timing got=%b/%0d/%0d want=1/1/%0d", it, obs_ready, obs_rsp, obs_lat, e_lat); end
            total++; if (obs_err !== e_err || obs_rdata !== e_rdata) begin bad++; $display("FAIL rnd%0d_rsp we=%b sz=%0d a=%h got=%b/%h want=%b/%h", it, we, size, addr, obs_err, obs_rdata, e_err, e_rdata); end
            total++; if (obs_beats !== e_beats || obs_unstable !== 0) begin bad++; $display("FAIL rnd%0d_beats got=%0d/%0d want=%0d/0", it, obs_beats, obs_unstable, e_beats); end
            if (e_beats >= 1) begin
                total++; if (obs_addr[0] !== {addr[31:2], 2'b00} || obs_we[0] !== we || obs_be[0] !== (we ? mask8[3:0] : 4'b0000) || (we && obs_wdata[0] !== lane[31:0])) begin bad++; $display("FAIL rnd%0d_beat0 got=%h/%b/%b/%h want=%h/%b/%b/%h", it, obs_addr[0], obs_we[0], obs_be[0], obs_wdata[0], {addr[31:2], 2'b00}, we, mask8[3:0], lane[31:0]); end
            end
            if (e_beats == 2) begin
                total++; if (obs_addr[1] !== {addr[31:2], 2'b00} + 32'd4 || obs_we[1] !== we || obs_be[1] !== (we ? mask8[7:4] : 4'b0000) || (we && obs_wdata[1] !== lane[63:32])) begin bad++; $display("FAIL rnd%0d_beat1 got=%h/%b/%b/%h want=%h/%b/%b/%h", it, obs_addr[1], obs_we[1], obs_be[1], obs_wdata[1], {addr[31:2], 2'b00} + 32'd4, we, mask8[7:4], lane[63:32]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        int rsp_seen, req_seen;
        sel = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'd2; req_addr = 32'h3001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h01020304;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h3004) begin bad++; $display("FAIL rmid_in_beat1 got=%b/%h want=1/00003004", mem_req, mem_addr); end
        #2 rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || mem_addr !== 32'd0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rmid_async got=%b/%h/%b/%b want=0/0/0/1", mem_req, mem_addr, rsp_valid, req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_seen = 0; req_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) rsp_seen++;
            if (mem_req) req_seen++;
            @(posedge clk); #1;
        end
        total++; if (rsp_seen !== 0 || req_seen !== 0) begin bad++; $display("FAIL rmid_no_rsp got=%0d/%0d want=0/0", rsp_seen, req_seen); end
        run_access(1'b0, 3'd1, 32'h3002, 32'h0, 1, 0, 32'h80010000, 32'h0);
        total++; if (obs_rsp !== 1 || obs_lat !== 3 || obs_err !== 1'b0 || obs_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL rmid_next got=%0d/%0d/%b/%h want=1/3/0/ffff8001", obs_rsp, obs_lat, obs_err, obs_rdata); end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        test_reset();
        test_directed();
        test_reject();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
